pipe_ctrl: RTL

Parametrised pipeline enable/clear controller for the MIPS core. It generalises the single-source data-stall gate into a per-stage enable and clear vector, and adds a redirect-flush path. It also owns an internal multiply/divide busy counter that stalls HI/LO consumers for the unit's latency, plus a saturating stall-cycle counter. It sits beside the hazard unit and drives the write-enable and synchronous-clear pins of the PC and every pipeline register.

---
 rtl/pipe_ctrl_if.sv | 30 +++
 rtl/pipe_ctrl.sv | 75 +++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the hazard unit (master) and the pipeline enable/clear controller (slave).
// All signals are levels sampled every cycle; there is no valid/ready handshake, each cycle stands alone.
interface pipe_ctrl_if #(
  parameter int STAGES = 5,
  parameter int CNT_W  = 4,
  parameter int PERF_W = 16
);
  logic              data_stall_i;
  logic              md_start_i;
  logic              md_is_div_i;
  logic              md_use_d_i;
  logic              flush_i;
  logic [STAGES-1:0] stage_en_o;
  logic [STAGES-1:0] stage_clr_o;
  logic              stall_o;
  logic              md_busy_o;
  logic [CNT_W-1:0]  md_cnt_o;
  logic              md_err_o;
  logic [PERF_W-1:0] stall_cycles_o;

  modport master (
    output data_stall_i, md_start_i, md_is_div_i, md_use_d_i, flush_i,
    input  stage_en_o, stage_clr_o, stall_o, md_busy_o, md_cnt_o, md_err_o, stall_cycles_o
  );

  modport slave (
    input  data_stall_i, md_start_i, md_is_div_i, md_use_d_i, flush_i,
    output stage_en_o, stage_clr_o, stall_o, md_busy_o, md_cnt_o, md_err_o, stall_cycles_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Per-stage enable/clear generation for the MIPS pipeline, with md-unit busy tracking,
// redirect flush priority and a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int STAGES      = 5,
  parameter int MULT_CYC    = 5,
  parameter int DIV_CYC     = 10,
  parameter int CNT_W       = 4,
  parameter int FLUSH_DEPTH = 1,
  parameter int PERF_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  pipe_ctrl_if.slave bus
);

  logic [CNT_W-1:0]  r_md_cnt;
  logic              r_md_err;
  logic [PERF_W-1:0] r_stall_cyc;

  logic              w_start_blk;
  logic              w_md_busy;
  logic              w_md_hazard;
  logic              w_stall;
  logic [STAGES-1:0] w_en;
  logic [STAGES-1:0] w_clr;

  // A deep flush also bubbles D/E, so the mult/div sitting there must not start.
  assign w_start_blk = (FLUSH_DEPTH >= 2) && bus.flush_i;
  assign w_md_busy   = (r_md_cnt != '0);
  assign w_md_hazard = bus.md_use_d_i & (w_md_busy | (bus.md_start_i & ~w_start_blk));
  assign w_stall     = (bus.data_stall_i | w_md_hazard) & ~bus.flush_i & reset;

  always_comb begin
    w_en  = '1;
    w_clr = '0;
    if (!reset) begin
      w_en  = '0;
      w_clr = '1;
    end else if (bus.flush_i) begin
      for (int k = 1; k < STAGES; k++) begin
        if (k <= FLUSH_DEPTH) w_clr[k] = 1'b1;
      end
    end else if (w_stall) begin
      w_en[0]  = 1'b0;
      w_en[1]  = 1'b0;
      w_clr[2] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_md_cnt    <= '0;
      r_md_err    <= 1'b0;
      r_stall_cyc <= '0;
    end else begin
      if (!w_md_busy && bus.md_start_i && !w_start_blk) begin
        r_md_cnt <= bus.md_is_div_i ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
      end else if (w_md_busy) begin
        r_md_cnt <= r_md_cnt - 1'b1;
      end
      // A start while busy is dropped; remember it until reset.
      if (bus.md_start_i && w_md_busy) r_md_err <= 1'b1;
      if (w_stall && (r_stall_cyc != '1)) r_stall_cyc <= r_stall_cyc + 1'b1;
    end
  end

  assign bus.stage_en_o     = w_en;
  assign bus.stage_clr_o    = w_clr;
  assign bus.stall_o        = w_stall;
  assign bus.md_busy_o      = w_md_busy;
  assign bus.md_cnt_o       = r_md_cnt;
  assign bus.md_err_o       = r_md_err;
  assign bus.stall_cycles_o = r_stall_cyc;

endmodule
